slave_port_arbiter: RTL and testbench

SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

---
 rtl/slave_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_slave_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_port_arbiter.sv
// Two-master arbiter for one slave port: captures rising-edge requests per master,
// grants round-robin, issues a one-cycle slave request, and returns an ack or a timeout.
module slave_port_arbiter #(
    parameter logic SLAVE_SEL = 1'b0,
    parameter int   TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        master_1_req,
    input  logic [31:0] master_1_addr,
    input  logic        master_1_cmd,
    input  logic [31:0] master_1_wdata,
    output logic        master_1_ack,
    output logic [31:0] master_1_rdata,
    input  logic        master_2_req,
    input  logic [31:0] master_2_addr,
    input  logic        master_2_cmd,
    input  logic [31:0] master_2_wdata,
    output logic        master_2_ack,
    output logic [31:0] master_2_rdata,
    output logic        slave_req,
    output logic [31:0] slave_addr,
    output logic        slave_cmd,
    output logic [31:0] slave_wdata,
    input  logic        slave_ack,
    input  logic [31:0] slave_rdata,
    output logic        timeout_err
);
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
    localparam logic [7:0]  TIMEOUT_CNT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [1:0]       req, req_d, pending, capture, in_cmd, lat_cmd, addr_hit;
    logic [1:0][31:0] in_addr, in_wdata, lat_addr, lat_wdata, rdata;
    logic             sel, sel_next;  // 0 = master 1, 1 = master 2
    logic             last_grant;
    logic [7:0]       cnt, cnt_inc;
    logic             done, timed_out, to_flag;

    assign req      = {master_2_req, master_1_req};
    assign in_addr  = {master_2_addr, master_1_addr};
    assign in_cmd   = {master_2_cmd, master_1_cmd};
    assign in_wdata = {master_2_wdata, master_1_wdata};
    assign addr_hit = {in_addr[1][31] == SLAVE_SEL, in_addr[0][31] == SLAVE_SEL};
    assign capture  = req & ~req_d & addr_hit & ~pending;

    assign cnt_inc   = cnt + 8'd1;
    assign done      = ((state == ISSUE) || (state == WAIT)) && slave_ack;
    assign timed_out = (state == WAIT) && !slave_ack && (cnt_inc == TIMEOUT_CNT);

    always_comb begin
        // NOTE: defaults first so every path assigns every variable; otherwise a latch is inferred.
        state_next = state;
        sel_next   = sel;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_next = ISSUE;
                    sel_next   = (&pending) ? ~last_grant : pending[1];
                end
            end
            ISSUE:   state_next = slave_ack ? RESP : WAIT;
            WAIT:    if (done || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: latched request fields and rdata are reset as well, since every output must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d       <= '0;
            pending     <= '0;
            lat_addr    <= '0;
            lat_cmd     <= '0;
            lat_wdata   <= '0;
            rdata       <= '0;
            sel         <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            to_flag     <= 1'b0;
            slave_addr  <= '0;
            slave_cmd   <= 1'b0;
            slave_wdata <= '0;
        end else begin
            req_d   <= req;
            sel     <= sel_next;
            to_flag <= timed_out;
            cnt     <= (state == WAIT) ? cnt_inc : 8'd0;

            for (int m = 0; m < 2; m++) begin
                if (capture[m]) begin
                    pending[m]   <= 1'b1;
                    lat_addr[m]  <= in_addr[m];
                    lat_cmd[m]   <= in_cmd[m];
                    lat_wdata[m] <= in_wdata[m];
                end else if ((done || timed_out) && (sel == 1'(m))) begin
                    pending[m] <= 1'b0;
                end
            end

            if ((state == IDLE) && (state_next == ISSUE)) begin
                slave_addr  <= lat_addr[sel_next];
                slave_cmd   <= lat_cmd[sel_next];
                slave_wdata <= lat_wdata[sel_next];
            end

            // Only reads return data; a timed-out read reports a recognisable poison word.
            if (!slave_cmd) begin
                if (done) begin
                    rdata[sel] <= slave_rdata;
                end else if (timed_out) begin
                    rdata[sel] <= TIMEOUT_RDATA;
                end
            end

            if (state == RESP) begin
                last_grant <= sel;
            end
        end
    end

    assign slave_req      = (state == ISSUE);
    assign master_1_ack   = (state == RESP) && !sel;
    assign master_2_ack   = (state == RESP) && sel;
    assign master_1_rdata = rdata[0];
    assign master_2_rdata = rdata[1];
    assign timeout_err    = (state == RESP) && to_flag;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Self-checking bench for slave_port_arbiter: vector table plus hand sequences,
// with a slave responder and scoreboard queues checked on every falling edge.
module tb_slave_port_arbiter;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m1_req, m1_cmd, m2_req, m2_cmd;
    logic [31:0] m1_addr, m1_wdata, m2_addr, m2_wdata;
    logic        master_1_ack, master_2_ack;
    logic [31:0] master_1_rdata, master_2_rdata;
    logic        slave_req, slave_cmd, slave_ack, timeout_err;
    logic [31:0] slave_addr, slave_wdata, slave_rdata;

    always #5 clk = ~clk;

    slave_port_arbiter #(.SLAVE_SEL(1'b0), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .master_1_req(m1_req), .master_1_addr(m1_addr), .master_1_cmd(m1_cmd),
        .master_1_wdata(m1_wdata), .master_1_ack(master_1_ack), .master_1_rdata(master_1_rdata),
        .master_2_req(m2_req), .master_2_addr(m2_addr), .master_2_cmd(m2_cmd),
        .master_2_wdata(m2_wdata), .master_2_ack(master_2_ack), .master_2_rdata(master_2_rdata),
        .slave_req(slave_req), .slave_addr(slave_addr), .slave_cmd(slave_cmd),
        .slave_wdata(slave_wdata), .slave_ack(slave_ack), .slave_rdata(slave_rdata),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        cmd;
        logic [31:0] wdata;
    } issue_t;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        to;
    } resp_t;

    // e1/e2: that master's transfer is expected to reach the slave; dly -1: slave never acks.
    typedef struct {
        logic        r1, r2;
        logic [31:0] a1, a2, w1, w2;
        logic        c1, c2;
        logic        e1, e2;
        int          first;
        int          dly;
        logic [31:0] sdata;
        logic        to;
    } vec_t;

    issue_t      issue_q[$];
    resp_t       resp_q[$];
    logic [31:0] model_rdata [1:2];
    vec_t        vecs [9];
    vec_t        v;
    int          n_checks = 0;
    int          n_err = 0;
    int          ack_delay = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    string       ctx = "reset";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %h, expected %h", ctx, name, act, exp);
        end
    endtask

    // One clock: monitor DUT outputs at the falling edge, then advance the slave responder.
    task automatic tick();
        issue_t ie;
        resp_t  re;
        @(negedge clk);
        check("one_ack_max", {31'b0, master_1_ack & master_2_ack}, 32'd0);
        if (slave_req) begin
            if (issue_q.size() == 0) begin
                check("spurious_slave_req", {31'b0, slave_req}, 32'd0);
            end else begin
                ie = issue_q.pop_front();
                check("slave_addr", slave_addr, ie.addr);
                check("slave_cmd", {31'b0, slave_cmd}, {31'b0, ie.cmd});
                check("slave_wdata", slave_wdata, ie.wdata);
            end
        end
        if (master_1_ack || master_2_ack) begin
            if (resp_q.size() == 0) begin
                check("spurious_ack", {30'b0, master_2_ack, master_1_ack}, 32'd0);
            end else begin
                re = resp_q.pop_front();
                check("ack_master", master_2_ack ? 32'd2 : 32'd1, 32'(re.m));
                check("master_rdata", (re.m == 2) ? master_2_rdata : master_1_rdata, re.rdata);
                check("timeout_err", {31'b0, timeout_err}, {31'b0, re.to});
            end
        end else if (timeout_err) begin
            check("spurious_timeout_err", {31'b0, timeout_err}, 32'd0);
        end

        if (!rst_n) begin
            slave_ack = 1'b0;
            rsp_cnt   = 0;
        end else begin
            if (slave_ack) slave_ack = 1'b0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    slave_ack   = 1'b1;
                    slave_rdata = rsp_data;
                end
            end else if (slave_req && ack_delay >= 0) begin
                if (ack_delay == 0) begin
                    slave_ack   = 1'b1;
                    slave_rdata = rsp_data;
                end else begin
                    rsp_cnt = ack_delay;
                end
            end
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] addr, input logic cmd,
                            input logic [31:0] wdata, input logic to, input logic [31:0] sdata);
        issue_t ie;
        resp_t  re;
        ie.addr  = addr;
        ie.cmd   = cmd;
        ie.wdata = wdata;
        issue_q.push_back(ie);
        if (!cmd) model_rdata[m] = to ? 32'hDEADBEEF : sdata;
        re.m     = m;
        re.rdata = model_rdata[m];
        re.to    = to;
        resp_q.push_back(re);
    endtask

    // Raise the requests for one clock and record what the slave and masters should see.
    task automatic launch(input vec_t t);
        m1_req = t.r1; m1_addr = t.a1; m1_cmd = t.c1; m1_wdata = t.w1;
        m2_req = t.r2; m2_addr = t.a2; m2_cmd = t.c2; m2_wdata = t.w2;
        ack_delay = t.dly;
        rsp_data  = t.sdata;
        if (t.first == 2) begin
            if (t.e2) push_exp(2, t.a2, t.c2, t.w2, t.to, t.sdata);
            if (t.e1) push_exp(1, t.a1, t.c1, t.w1, t.to, t.sdata);
        end else begin
            if (t.e1) push_exp(1, t.a1, t.c1, t.w1, t.to, t.sdata);
            if (t.e2) push_exp(2, t.a2, t.c2, t.w2, t.to, t.sdata);
        end
        tick();
        m1_req = 1'b0;
        m2_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((issue_q.size() != 0 || resp_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check("drain_outstanding", 32'(issue_q.size() + resp_q.size()), 32'd0);
        issue_q.delete();
        resp_q.delete();
        repeat (4) tick();
        check("m1_rdata_hold", master_1_rdata, model_rdata[1]);
        check("m2_rdata_hold", master_2_rdata, model_rdata[2]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        m1_req = 0; m1_addr = 0; m1_cmd = 0; m1_wdata = 0;
        m2_req = 0; m2_addr = 0; m2_cmd = 0; m2_wdata = 0;
        slave_ack = 0; slave_rdata = 0;
        model_rdata[1] = 0;
        model_rdata[2] = 0;

        //          r1 r2 a1            a2            w1            w2            c1 c2 e1 e2 first dly sdata         to
        vecs[0] = '{1, 0, 32'h7FFFFFFF, 32'h0,        32'h11111111, 32'h0,        1, 0, 1, 0, 1,  1, 32'h0,        0};
        vecs[1] = '{0, 1, 32'h0,        32'h7FFFFFFF, 32'h0,        32'h0,        0, 0, 0, 1, 2,  0, 32'h10000002, 0};
        vecs[2] = '{1, 1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h22222222, 0, 1, 1, 1, 1,  0, 32'hA5A5A5A5, 0};
        vecs[3] = '{1, 1, 32'h00001234, 32'h7FFF0000, 32'h33333333, 32'h0,        1, 0, 1, 1, 1,  2, 32'h12345678, 0};
        vecs[4] = '{1, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1,  0, 32'h99999999, 0};
        vecs[5] = '{1, 1, 32'h80000000, 32'h7FFF0008, 32'h0,        32'h0,        0, 0, 0, 1, 2,  1, 32'h0BADF00D, 0};
        vecs[6] = '{1, 0, 32'h0000ABCD, 32'h0,        32'h0,        32'h0,        0, 0, 1, 0, 1,  4, 32'hCAFEF00D, 0};
        vecs[7] = '{0, 1, 32'h0,        32'h00000040, 32'h0,        32'h0,        0, 0, 0, 1, 2, -1, 32'h0,        1};
        vecs[8] = '{1, 0, 32'h00000080, 32'h0,        32'h44444444, 32'h0,        1, 0, 1, 0, 1, -1, 32'h0,        1};

        #12;
        check("rst_slave_req", {31'b0, slave_req}, 32'd0);
        check("rst_slave_addr", slave_addr, 32'd0);
        check("rst_slave_wdata", slave_wdata, 32'd0);
        check("rst_slave_cmd", {31'b0, slave_cmd}, 32'd0);
        check("rst_acks", {30'b0, master_2_ack, master_1_ack}, 32'd0);
        check("rst_m1_rdata", master_1_rdata, 32'd0);
        check("rst_m2_rdata", master_2_rdata, 32'd0);
        check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ctx = $sformatf("vec%0d", i);
            launch(vecs[i]);
            drain();
        end

        ctx = "latency";
        v = '{1, 0, 32'h00000100, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 0, 32'h01020304, 0};
        launch(v);
        check("e0_slave_req", {31'b0, slave_req}, 32'd0);
        tick();
        check("e1_slave_req", {31'b0, slave_req}, 32'd1);
        tick();
        check("e2_master_ack", {31'b0, master_1_ack}, 32'd1);
        check("e2_slave_req", {31'b0, slave_req}, 32'd0);
        tick();
        check("e3_master_ack", {31'b0, master_1_ack}, 32'd0);
        drain();

        ctx = "timeout_timing";
        v = '{0, 1, 32'h0, 32'h00000200, 32'h0, 32'h0, 0, 0, 0, 1, 2, -1, 32'h0, 1};
        launch(v);
        n = 0;
        while (!slave_req && n < 10) begin tick(); n++; end
        n = 0;
        while (!master_2_ack && n < 20) begin tick(); n++; end
        check("issue_to_ack_cycles", 32'(n), 32'd5);
        check("timeout_err_at_ack", {31'b0, timeout_err}, 32'd1);
        drain();

        ctx = "pending_ignore";
        v = '{1, 0, 32'h00000300, 32'h0, 32'h66666666, 32'h0, 1, 0, 1, 0, 1, 2, 32'h0, 0};
        launch(v);
        tick();
        m1_req = 1'b1; m1_addr = 32'h00000304; m1_wdata = 32'h77777777;
        tick();
        m1_req = 1'b0;
        drain();

        ctx = "idle_slave_ack";
        slave_ack   = 1'b1;
        slave_rdata = 32'hBAD0BAD0;
        tick();
        repeat (3) tick();
        check("m1_rdata_kept", master_1_rdata, model_rdata[1]);
        check("m2_rdata_kept", master_2_rdata, model_rdata[2]);

        ctx = "reset_in_wait";
        v = '{1, 0, 32'h7FFF0004, 32'h0, 32'h5A5A5A5A, 32'h0, 1, 0, 1, 0, 1, -1, 32'h0, 0};
        launch(v);
        n = 0;
        while (!slave_req && n < 10) begin tick(); n++; end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("slave_req", {31'b0, slave_req}, 32'd0);
        check("slave_addr", slave_addr, 32'd0);
        check("slave_wdata", slave_wdata, 32'd0);
        check("slave_cmd", {31'b0, slave_cmd}, 32'd0);
        check("m1_rdata", master_1_rdata, 32'd0);
        check("m2_rdata", master_2_rdata, 32'd0);
        check("acks", {30'b0, master_2_ack, master_1_ack}, 32'd0);
        issue_q.delete();
        resp_q.delete();
        model_rdata[1] = 0;
        model_rdata[2] = 0;
        repeat (3) tick();
        #2 rst_n = 1'b1;
        ctx = "after_reset";
        v = '{1, 0, 32'h00000500, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 0, 32'h13572468, 0};
        launch(v);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
